seq_multiplier: RTL and testbench
=================================

// Module: seq_multiplier
// PURPOSE
//   Parametrised sequential radix-2 shift-add multiplier; successor to the 4-bit combinational multiply.
//   Computes P = A*B over WIDTH fixed cycles with valid/ready handshakes on both sides.
//   Sits in the execution unit wherever a full-width array multiplier is too large.
//   One operation in flight at a time.
// PARAMETERS
//   WIDTH      4    operand width in bits, legal 2..32; product is 2*WIDTH bits
//   CNT_W      $clog2(WIDTH+1)  step-counter width; derived, do not override
// PORTS
//   clk        in   1          single clock; all state on rising edge
//   rst_n      in   1          asynchronous, active-low reset
//   in_valid   in   1          operands A/B valid
//   in_ready   out  1          block can accept operands (high only in IDLE)
//   A          in   WIDTH      multiplicand
//   B          in   WIDTH      multiplier
//   out_valid  out  1          P holds a completed product
//   out_ready  in   1          consumer accepts P
//   P          out  2*WIDTH    product
//   busy       out  1          high in BUSY and DONE
//   is_signed  in   1          only with SEQ_MULT_SIGNED_EN; sampled with A/B
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, busy=0, P=0, counter=0.
//   - FSM: IDLE -(in_valid&in_ready)-> BUSY -(counter==WIDTH-1)-> DONE -(out_ready)-> IDLE.
//   - Accept edge: latch A into the multiplicand reg, B into the multiplier shift reg, clear the accumulator, counter=0.
//   - Each BUSY cycle: if multiplier LSB=1, add multiplicand<<counter to the accumulator;
//     then shift the multiplier right by 1 and increment the counter.
//   - Latency: fixed; out_valid rises exactly WIDTH clocks after the accept edge. No zero-operand early exit.
//   - DONE: out_valid=1 and P stable until the out_ready handshake; the next edge returns to IDLE, out_valid=0.
//   - No back-to-back overlap: in_ready=0 in BUSY and DONE; earliest next accept is one cycle after the output handshake.
//   - out_ready is ignored outside DONE. in_valid is ignored while in_ready=0; A/B may change freely then.
//   - P keeps the last product after the handshake and updates only when the next result completes.
//   - Width: unsigned exact 2*WIDTH-bit result, no overflow possible.
//     Accumulator 2*WIDTH bits; adder WIDTH+1 bits wide at each step.
//   - rst_n asserted mid-operation aborts immediately. No out_valid is produced for the aborted operands.
// CONFIGURATION
//   SEQ_MULT_SIGNED_EN
//     defined:   port is_signed exists.
//                is_signed=1: A/B are two's complement; operands are converted to magnitudes on the accept edge.
//                The sign flag (A[MSB]^B[MSB]) is registered; the final product is negated when entering DONE.
//                Latency is unchanged (WIDTH).
//                is_signed=0: identical to unsigned.
//     undefined: no is_signed port; unsigned only; no negation logic.
// STRUCTURE
//   - Package seq_mult_pkg: FSM state encoding localparams (S_IDLE=2'd0, S_BUSY=2'd1, S_DONE=2'd2).
//     Also holds the MAX_WIDTH=32 constant used for the legality check.
//   - Sub-module seq_mult_ctrl: FSM, step counter and handshake outputs.
//     It drives load/step/finish strobes to the datapath in the top.
//   - Datapath (operand regs, shift reg, accumulator, optional sign fix-up) stays in seq_multiplier.
// TESTING (WIDTH=4 unless noted)
//   1 A=9,B=9, out_ready=1 -> out_valid exactly 4 clks after accept, P=8'h51 (81); in_ready=0 until handshake.
//   2 A=15,B=15 then A=0,B=13 -> P=8'hE1 (225), then P=8'h00; both with identical latency.
//   3 A=10,B=10, out_ready=0 for 6 clks after DONE -> P=8'h64 held, out_valid held, in_valid pulses ignored.
//   4 rst_n low 2 clks into BUSY with A=8,B=8 -> all outputs at reset values at once;
//     next op A=2,B=2 -> P=8'h04, no spurious out_valid in between.
//   5 SEQ_MULT_SIGNED_EN, is_signed=1:
//     A=4'h8,B=4'h8 -> P=8'h40 (64); A=4'h8,B=4'h7 -> P=8'hC8 (-56); is_signed=0, A=B=4'hF -> P=8'hE1.
//   6 WIDTH=16, A=16'hFFFF,B=16'hFFFF -> P=32'hFFFE0001 after 16 clks;
//     random 1000-op regression vs behavioural A*B with random back-pressure.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared constants for the sequential shift-add multiplier.
//   S_IDLE/S_BUSY/S_DONE : controller state encoding
//   MAX_WIDTH            : largest legal operand width
//   width_legal()        : legality check used at elaboration
package seq_mult_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic bit width_legal(input int unsigned w);
        return (w >= 2) && (w <= MAX_WIDTH);
    endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: FSM, step counter and handshake outputs for seq_multiplier.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_in_valid        operands offered
//   i_out_ready       consumer accepts the product
//   o_in_ready        high only in IDLE
//   o_out_valid       high only in DONE
//   o_busy            high in BUSY and DONE
//   o_load            accept strobe: datapath latches operands
//   o_step            one shift-add step this cycle
//   o_finish          last step: datapath registers the product
//   o_cnt             current step index (shift amount)
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    input  logic             i_out_ready,
    output logic             o_in_ready,
    output logic             o_out_valid,
    output logic             o_busy,
    output logic             o_load,
    output logic             o_step,
    output logic             o_finish,
    output logic [CNT_W-1:0] o_cnt
);

    logic [1:0]       r_state;
    logic [1:0]       w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic             w_last;

    assign w_last = (r_state == S_BUSY) && (r_cnt == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (i_in_valid) begin
                    w_state_d = S_BUSY;
                    w_cnt_d   = '0;
                end
            end
            S_BUSY: begin
                w_cnt_d = r_cnt + CNT_W'(1);
                if (w_last) begin
                    w_state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (i_out_ready) begin
                    w_state_d = S_IDLE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    // Outputs and datapath strobes
    always_comb begin
        o_in_ready  = (r_state == S_IDLE);
        o_out_valid = (r_state == S_DONE);
        o_busy      = (r_state == S_BUSY) || (r_state == S_DONE);
        o_load      = (r_state == S_IDLE) && i_in_valid;
        o_step      = (r_state == S_BUSY);
        o_finish    = w_last;
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-add multiplier, P = A*B in WIDTH cycles, one op in flight.
// Optional feature macro: SEQ_MULT_SIGNED_EN adds the is_signed port (two's complement mode).
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    operand handshake (in_ready high only when idle)
//   A, B                   multiplicand, multiplier (WIDTH bits)
//   is_signed              (SEQ_MULT_SIGNED_EN only) treat A/B as signed, sampled with A/B
//   out_valid / out_ready  product handshake
//   P                      product (2*WIDTH bits), held until the next result completes
//   busy                   high while an operation is running or waiting to be taken
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic               is_signed,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] P,
    output logic               busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    if (!width_legal(WIDTH)) begin : g_bad_width
        $error("seq_multiplier: WIDTH must be in 2..%0d", MAX_WIDTH);
    end

    logic             w_load;
    logic             w_step;
    logic             w_finish;
    logic [CNT_W-1:0] w_cnt;

    seq_mult_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (in_valid),
        .i_out_ready (out_ready),
        .o_in_ready  (in_ready),
        .o_out_valid (out_valid),
        .o_busy      (busy),
        .o_load      (w_load),
        .o_step      (w_step),
        .o_finish    (w_finish),
        .o_cnt       (w_cnt)
    );

    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_p;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_addend;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod;

`ifdef SEQ_MULT_SIGNED_EN
    logic r_neg;
    logic w_neg_in;

    // Multiply magnitudes; the sign is restored when the product is registered.
    assign w_a_mag  = (is_signed && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
    assign w_b_mag  = (is_signed && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;
    assign w_neg_in = is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
    assign w_prod   = r_neg ? (~w_acc_next + (2*WIDTH)'(1)) : w_acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg <= 1'b0;
        end else if (w_load) begin
            r_neg <= w_neg_in;
        end
    end
`else
    assign w_a_mag = A;
    assign w_b_mag = B;
    assign w_prod  = w_acc_next;
`endif

    // Partial product aligned to the current step; only WIDTH+1 bits of the sum can change.
    assign w_addend   = {{WIDTH{1'b0}}, r_mcand} << w_cnt;
    assign w_acc_next = r_mplier[0] ? (r_acc + w_addend) : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (w_load) begin
            r_mcand  <= w_a_mag;
            r_mplier <= w_b_mag;
            r_acc    <= '0;
        end else if (w_step) begin
            r_acc    <= w_acc_next;
            r_mplier <= r_mplier >> 1;
        end
    end

    // The last step's sum goes straight into P as the FSM enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p <= '0;
        end else if (w_finish) begin
            r_p <= w_prod;
        end
    end

    assign P = r_p;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: self-checking bench for seq_multiplier (WIDTH=4 and WIDTH=16 instances).
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=4 instance
    logic       in_valid4 = 1'b0, out_ready4 = 1'b0, sg4 = 1'b0;
    logic [3:0] A4 = '0, B4 = '0;
    logic       in_ready4, out_valid4, busy4;
    logic [7:0] P4;

    // WIDTH=16 instance
    logic        in_valid16 = 1'b0, out_ready16 = 1'b0, sg16 = 1'b0;
    logic [15:0] A16 = '0, B16 = '0;
    logic        in_ready16, out_valid16, busy16;
    logic [31:0] P16;

    seq_multiplier #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .A         (A4),
        .B         (B4),
`ifdef SEQ_MULT_SIGNED_EN
        .is_signed (sg4),
`endif
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .P         (P4),
        .busy      (busy4)
    );

    seq_multiplier #(.WIDTH(16)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .A         (A16),
        .B         (B16),
`ifdef SEQ_MULT_SIGNED_EN
        .is_signed (sg16),
`endif
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .P         (P16),
        .busy      (busy16)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: exact product of the operands, signed or unsigned, truncated to 2*w bits.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input bit sg, input int w);
        longint sa, sb, prod;
        logic [63:0] mask;
        sa = longint'(a);
        sb = longint'(b);
        if (sg && a[w-1]) sa = sa - (longint'(1) << w);
        if (sg && b[w-1]) sb = sb - (longint'(1) << w);
        prod = sa * sb;
        mask = (64'd1 << (2 * w)) - 64'd1;
        return 64'(prod) & mask;
    endfunction

    // One WIDTH=4 operation, called at a negedge in IDLE. 'hold' cycles of back-pressure with
    // in_valid pulses that must be ignored.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic sg, input int hold,
                        output logic [7:0] p, output int lat);
        int  n;
        bit  leak;
        leak = 1'b0;
        A4 = a; B4 = b; sg4 = sg; in_valid4 = 1'b1; out_ready4 = (hold == 0);
        check("in_ready_idle", 64'(in_ready4), 64'd1);
        tick();
        in_valid4 = 1'b0; A4 = ~a; B4 = ~b;
        n = 0;
        while (!out_valid4 && n < 40) begin
            if (in_ready4 || !busy4) leak = 1'b1;
            tick();
            n++;
        end
        lat = n;
        p = P4;
        if (!out_valid4) begin
            check("out_valid_timeout", 64'(out_valid4), 64'd1);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            if (in_ready4 || !out_valid4 || P4 !== p) leak = 1'b1;
            in_valid4 = i[0];
            A4 = 4'(i);
            tick();
        end
        in_valid4 = 1'b0;
        out_ready4 = 1'b1;
        if (!out_valid4 || P4 !== p) leak = 1'b1;
        tick();
        out_ready4 = 1'b0;
        check("ready_blocked_busy", 64'(leak), 64'd0);
        check("valid_drop_after_hs", 64'(out_valid4), 64'd0);
        check("ready_after_hs", 64'(in_ready4), 64'd1);
        check("p_kept_after_hs", 64'(P4), 64'(p));
    endtask

    // One WIDTH=16 operation with random back-pressure.
    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic sg,
                         output logic [31:0] p, output int lat, output bit ok);
        int n;
        bit hs;
        A16 = a; B16 = b; sg16 = sg; in_valid16 = 1'b1; out_ready16 = 1'b0;
        ok = in_ready16;
        tick();
        in_valid16 = 1'b0; A16 = 16'($urandom); B16 = 16'($urandom);
        n = 0;
        while (!out_valid16 && n < 60) begin
            tick();
            n++;
        end
        lat = n;
        p = P16;
        if (!out_valid16) begin
            ok = 1'b0;
            return;
        end
        n = 0;
        hs = 1'b0;
        while (!hs && n < 50) begin
            out_ready16 = ($urandom_range(0, 2) == 0);
            hs = out_ready16;
            if (!out_valid16 || P16 !== p) ok = 1'b0;
            tick();
            n++;
        end
        out_ready16 = 1'b0;
        if (!hs || out_valid16 || !in_ready16) ok = 1'b0;
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sg;
        int         hold;
        logic [7:0] p;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [7:0]  p4;
        logic [31:0] p16;
        logic [15:0] ra, rb;
        logic        rs;
        int          lat;
        int          spurious;
        bit          ok;

        vecs[0] = '{4'd9,  4'd9,  1'b0, 0, 8'h51};
        vecs[1] = '{4'd15, 4'd15, 1'b0, 0, 8'hE1};
        vecs[2] = '{4'd0,  4'd13, 1'b0, 0, 8'h00};
        vecs[3] = '{4'd10, 4'd10, 1'b0, 6, 8'h64};
        vecs[4] = '{4'd1,  4'd15, 1'b0, 0, 8'h0F};
        vecs[5] = '{4'd15, 4'd1,  1'b0, 2, 8'h0F};
        vecs[6] = '{4'd13, 4'd0,  1'b0, 0, 8'h00};
        vecs[7] = '{4'd11, 4'd12, 1'b0, 1, 8'h84};
        vecs[8] = '{4'd7,  4'd6,  1'b0, 0, 8'h2A};

        // Reset state
        #12;
        check("rst_in_ready", 64'(in_ready4), 64'd1);
        check("rst_out_valid", 64'(out_valid4), 64'd0);
        check("rst_busy", 64'(busy4), 64'd0);
        check("rst_p", 64'(P4), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed vectors
        foreach (vecs[i]) begin
            run4(vecs[i].a, vecs[i].b, vecs[i].sg, vecs[i].hold, p4, lat);
            check($sformatf("vec%0d_p", i), 64'(p4), 64'(vecs[i].p));
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'd4);
        end

        // Reset two clocks into BUSY aborts the operation
        A4 = 4'd8; B4 = 4'd8; in_valid4 = 1'b1; out_ready4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        tick();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid4), 64'd0);
        check("abort_in_ready", 64'(in_ready4), 64'd1);
        check("abort_busy", 64'(busy4), 64'd0);
        check("abort_p", 64'(P4), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid4 || busy4) spurious++;
            tick();
        end
        check("abort_no_valid", 64'(spurious), 64'd0);
        out_ready4 = 1'b0;
        run4(4'd2, 4'd2, 1'b0, 0, p4, lat);
        check("post_abort_p", 64'(p4), 64'h04);
        check("post_abort_lat", 64'(lat), 64'd4);

`ifdef SEQ_MULT_SIGNED_EN
        run4(4'h8, 4'h8, 1'b1, 0, p4, lat);
        check("signed_m8_m8", 64'(p4), 64'h40);
        check("signed_lat", 64'(lat), 64'd4);
        run4(4'h8, 4'h7, 1'b1, 0, p4, lat);
        check("signed_m8_7", 64'(p4), 64'hC8);
        run4(4'hF, 4'hF, 1'b0, 0, p4, lat);
        check("unsigned_f_f", 64'(p4), 64'hE1);
        for (int i = 0; i < 40; i++) begin
            ra[3:0] = 4'($urandom);
            rb[3:0] = 4'($urandom);
            rs = 1'($urandom);
            run4(ra[3:0], rb[3:0], rs, 0, p4, lat);
            check("rand4_signed", 64'(p4), ref_mul(32'(ra[3:0]), 32'(rb[3:0]), rs, 4));
        end
`endif

        // WIDTH=16 corner plus randomized regression
        run16(16'hFFFF, 16'hFFFF, 1'b0, p16, lat, ok);
        check("w16_ffff_p", 64'(p16), 64'hFFFE0001);
        check("w16_ffff_lat", 64'(lat), 64'd16);
        check("w16_ffff_hs", 64'(ok), 64'd1);
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 7 == 0) ra = 16'h0;
`ifdef SEQ_MULT_SIGNED_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            run16(ra, rb, rs, p16, lat, ok);
            check("w16_rand_p", 64'(p16), ref_mul(32'(ra), 32'(rb), rs, 16));
            check("w16_rand_lat", 64'(lat), 64'd16);
            check("w16_rand_hs", 64'(ok), 64'd1);
            for (int k = $urandom_range(0, 2); k > 0; k--) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
